// File: rtl/avalon_mem_arbiter_if.sv
// Avalon-MM bus bundle shared by the two CPU masters and the memory slave.
// "master" is the side that issues transfers; "slave" is the side that answers them.
interface avalon_mem_arbiter_if;
    logic [31:0] address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic        waitrequest;
    logic [31:0] readdata;

    modport master (
        output address, read, write, writedata, byteenable,
        input  waitrequest, readdata
    );

    modport slave (
        input  address, read, write, writedata, byteenable,
        output waitrequest, readdata
    );
endinterface

// File: rtl/avalon_mem_arbiter.sv
// Round-robin two-master Avalon-MM arbiter in front of one fixed-read-latency memory slave.
// One transfer is in flight at a time; a master is released only in its single completion cycle.
module avalon_mem_arbiter #(
    parameter int READ_LATENCY = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    avalon_mem_arbiter_if.slave  m0,
    avalon_mem_arbiter_if.slave  m1,
    avalon_mem_arbiter_if.master s
);
    localparam logic [2:0] LAT = 3'(READ_LATENCY);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        RDWAIT = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_state_next;
    logic       r_grant;
    logic       w_grant_next;
    logic       r_last;
    logic       w_last_next;
    logic       r_is_write;
    logic       w_is_write_next;
    logic [2:0] r_lat_cnt;
    logic [2:0] w_lat_cnt_next;
    logic       w_req0;
    logic       w_req1;
    logic       w_done;

    assign w_req0 = m0.read | m0.write;
    assign w_req1 = m1.read | m1.write;

    assign m0.readdata = s.readdata;
    assign m1.readdata = s.readdata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_grant    <= 1'b0;
            r_last     <= 1'b0;
            r_is_write <= 1'b0;
            r_lat_cnt  <= 3'd0;
        end else begin
            r_state    <= w_state_next;
            r_grant    <= w_grant_next;
            r_last     <= w_last_next;
            r_is_write <= w_is_write_next;
            r_lat_cnt  <= w_lat_cnt_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_grant_next    = r_grant;
        w_last_next     = r_last;
        w_is_write_next = r_is_write;
        w_lat_cnt_next  = r_lat_cnt;
        w_done          = 1'b0;
        s.address       = '0;
        s.read          = 1'b0;
        s.write         = 1'b0;
        s.writedata     = '0;
        s.byteenable    = '0;

        case (r_state)
            IDLE: begin
                if (w_req0 || w_req1) begin
                    // On a tie the master that did not finish last goes next.
                    w_grant_next    = (w_req0 && w_req1) ? ~r_last : w_req1;
                    // The transfer type is latched so a dropped request still finishes cleanly.
                    w_is_write_next = w_grant_next ? m1.write : m0.write;
                    w_state_next    = ISSUE;
                end
            end

            ISSUE: begin
                s.address    = r_grant ? m1.address    : m0.address;
                s.writedata  = r_grant ? m1.writedata  : m0.writedata;
                s.byteenable = r_grant ? m1.byteenable : m0.byteenable;
                s.write      = r_is_write;
                s.read       = ~r_is_write;
                if (!s.waitrequest) begin
                    if (r_is_write) begin
                        w_done       = 1'b1;
                        w_last_next  = r_grant;
                        w_state_next = IDLE;
                    end else begin
                        w_lat_cnt_next = 3'd1;
                        w_state_next   = RDWAIT;
                    end
                end
            end

            RDWAIT: begin
                if (r_lat_cnt == LAT) begin
                    w_done         = 1'b1;
                    w_last_next    = r_grant;
                    w_lat_cnt_next = 3'd0;
                    w_state_next   = IDLE;
                end else begin
                    w_lat_cnt_next = r_lat_cnt + 3'd1;
                end
            end

            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    assign m0.waitrequest = ~(w_done & ~r_grant);
    assign m1.waitrequest = ~(w_done & r_grant);

endmodule
